// File: rtl/bsg_global_buffer_bank_sched_if.sv
// Request/bank bundle for the global buffer bank scheduler.
// slave: scheduler side; master: ring endpoints, rw port and SRAM side.
interface bsg_global_buffer_bank_sched_if #(
    parameter int data_width_p = -1,
    parameter int bank_els_p   = -1,
    parameter int queue_els_p  = 4
);
    localparam int bank_addr_width_lp =
        (bank_els_p <= 1) ? 1 : $clog2(bank_els_p);
    localparam int cnt_width_lp =
        (queue_els_p + 1 <= 1) ? 1 : $clog2(queue_els_p + 1);

    logic [bank_addr_width_lp-1:0] ro_addr_i;
    logic                          ro_v_i;
    logic [bank_addr_width_lp-1:0] wo_addr_i;
    logic [data_width_p-1:0]       wo_data_i;
    logic                          wo_v_i;
    logic [bank_addr_width_lp-1:0] rw_addr_i;
    logic [data_width_p-1:0]       rw_data_i;
    logic                          rw_w_i;
    logic                          rw_v_i;
    logic                          rw_yumi_o;
    logic [bank_addr_width_lp-1:0] mem_addr_o;
    logic [data_width_p-1:0]       mem_data_o;
    logic                          mem_w_o;
    logic                          mem_v_o;
    logic [data_width_p-1:0]       mem_data_i;
    logic [data_width_p-1:0]       ro_data_o;
    logic                          ro_data_v_o;
    logic [data_width_p-1:0]       rw_data_o;
    logic                          rw_data_v_o;
    logic [cnt_width_lp-1:0]       ro_count_o;
    logic [cnt_width_lp-1:0]       wo_count_o;
    logic                          overflow_o;

    modport slave (
        input  ro_addr_i, ro_v_i,
        input  wo_addr_i, wo_data_i, wo_v_i,
        input  rw_addr_i, rw_data_i, rw_w_i, rw_v_i,
        input  mem_data_i,
        output rw_yumi_o,
        output mem_addr_o, mem_data_o, mem_w_o, mem_v_o,
        output ro_data_o, ro_data_v_o,
        output rw_data_o, rw_data_v_o,
        output ro_count_o, wo_count_o, overflow_o
    );

    modport master (
        output ro_addr_i, ro_v_i,
        output wo_addr_i, wo_data_i, wo_v_i,
        output rw_addr_i, rw_data_i, rw_w_i, rw_v_i,
        output mem_data_i,
        input  rw_yumi_o,
        input  mem_addr_o, mem_data_o, mem_w_o, mem_v_o,
        input  ro_data_o, ro_data_v_o,
        input  rw_data_o, rw_data_v_o,
        input  ro_count_o, wo_count_o, overflow_o
    );
endinterface

// File: rtl/bsg_global_buffer_bank_sched.sv
// Shares one single-port SRAM bank among ro ring, wo ring and local rw port.
// Ports: clk_i, reset_i (async, active-high), bus (slave modport of the _if).
module bsg_global_buffer_bank_sched #(
    parameter int data_width_p = -1,
    parameter int bank_els_p   = -1,
    parameter int queue_els_p  = 4
) (
    input logic clk_i,
    input logic reset_i,
    bsg_global_buffer_bank_sched_if.slave bus
);
    localparam int bank_addr_width_lp =
        (bank_els_p <= 1) ? 1 : $clog2(bank_els_p);
    localparam int cnt_width_lp =
        (queue_els_p + 1 <= 1) ? 1 : $clog2(queue_els_p + 1);
    localparam int ptr_width_lp =
        (queue_els_p <= 2) ? 1 : $clog2(queue_els_p);

    typedef logic [bank_addr_width_lp-1:0] addr_t;
    typedef logic [data_width_p-1:0]       data_t;
    typedef logic [cnt_width_lp-1:0]       cnt_t;
    typedef logic [ptr_width_lp-1:0]       ptr_t;

    typedef enum logic [1:0] {
        LAST_RW = 2'd0,
        LAST_WO = 2'd1,
        LAST_RO = 2'd2
    } last_e;

    localparam cnt_t full_cnt_lp = cnt_t'(queue_els_p);
    localparam ptr_t last_ptr_lp = ptr_t'(queue_els_p - 1);

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    addr_t ro_mem_q      [queue_els_p];
    addr_t wo_addr_mem_q [queue_els_p];
    data_t wo_data_mem_q [queue_els_p];

    ptr_t  ro_wptr_q, ro_wptr_d, ro_rptr_q, ro_rptr_d;
    ptr_t  wo_wptr_q, wo_wptr_d, wo_rptr_q, wo_rptr_d;
    cnt_t  ro_cnt_q, ro_cnt_d, wo_cnt_q, wo_cnt_d;
    last_e last_q, last_d;
    logic  overflow_q, overflow_d;
    logic  ro_data_v_q, ro_data_v_d;
    logic  rw_data_v_q, rw_data_v_d;

    logic  gnt_ro, gnt_wo, gnt_rw, rr_gnt;
    logic  ro_full, wo_full, ro_ne, wo_ne;
    logic  ro_enq, wo_enq, ro_drop, wo_drop;

    assign ro_full = (ro_cnt_q == full_cnt_lp);
    assign wo_full = (wo_cnt_q == full_cnt_lp);
    assign ro_ne   = (ro_cnt_q != '0);
    assign wo_ne   = (wo_cnt_q != '0);

    // Urgency beats round-robin; only round-robin wins move the pointer.
    always_comb begin
        gnt_ro = 1'b0;
        gnt_wo = 1'b0;
        gnt_rw = 1'b0;
        rr_gnt = 1'b0;
        if (!reset_i) begin
            if (ro_full) begin
                gnt_ro = 1'b1;
            end else if (wo_full) begin
                gnt_wo = 1'b1;
            end else begin
                rr_gnt = 1'b1;
                case (last_q)
                    LAST_RO: begin
                        if (bus.rw_v_i)  gnt_rw = 1'b1;
                        else if (wo_ne)  gnt_wo = 1'b1;
                        else if (ro_ne)  gnt_ro = 1'b1;
                    end
                    LAST_RW: begin
                        if (wo_ne)           gnt_wo = 1'b1;
                        else if (ro_ne)      gnt_ro = 1'b1;
                        else if (bus.rw_v_i) gnt_rw = 1'b1;
                    end
                    default: begin
                        if (ro_ne)           gnt_ro = 1'b1;
                        else if (bus.rw_v_i) gnt_rw = 1'b1;
                        else if (wo_ne)      gnt_wo = 1'b1;
                    end
                endcase
            end
        end
    end

    // A full queue still accepts when it is being drained the same cycle.
    assign ro_enq  = bus.ro_v_i & (~ro_full | gnt_ro);
    assign wo_enq  = bus.wo_v_i & (~wo_full | gnt_wo);
    assign ro_drop = bus.ro_v_i & ro_full & ~gnt_ro;
    assign wo_drop = bus.wo_v_i & wo_full & ~gnt_wo;

    always_comb begin
        last_d      = last_q;
        ro_wptr_d   = ro_enq ? ptr_inc(ro_wptr_q) : ro_wptr_q;
        ro_rptr_d   = gnt_ro ? ptr_inc(ro_rptr_q) : ro_rptr_q;
        wo_wptr_d   = wo_enq ? ptr_inc(wo_wptr_q) : wo_wptr_q;
        wo_rptr_d   = gnt_wo ? ptr_inc(wo_rptr_q) : wo_rptr_q;
        ro_cnt_d    = ro_cnt_q;
        wo_cnt_d    = wo_cnt_q;
        overflow_d  = overflow_q | ro_drop | wo_drop;
        ro_data_v_d = gnt_ro;
        rw_data_v_d = gnt_rw & ~bus.rw_w_i;
        if (ro_enq & ~gnt_ro)      ro_cnt_d = ro_cnt_q + 1'b1;
        else if (~ro_enq & gnt_ro) ro_cnt_d = ro_cnt_q - 1'b1;
        if (wo_enq & ~gnt_wo)      wo_cnt_d = wo_cnt_q + 1'b1;
        else if (~wo_enq & gnt_wo) wo_cnt_d = wo_cnt_q - 1'b1;
        if (rr_gnt) begin
            if (gnt_rw)      last_d = LAST_RW;
            else if (gnt_wo) last_d = LAST_WO;
            else if (gnt_ro) last_d = LAST_RO;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ro_wptr_q   <= '0;
            ro_rptr_q   <= '0;
            wo_wptr_q   <= '0;
            wo_rptr_q   <= '0;
            ro_cnt_q    <= '0;
            wo_cnt_q    <= '0;
            last_q      <= LAST_RO;
            overflow_q  <= 1'b0;
            ro_data_v_q <= 1'b0;
            rw_data_v_q <= 1'b0;
        end else begin
            ro_wptr_q   <= ro_wptr_d;
            ro_rptr_q   <= ro_rptr_d;
            wo_wptr_q   <= wo_wptr_d;
            wo_rptr_q   <= wo_rptr_d;
            ro_cnt_q    <= ro_cnt_d;
            wo_cnt_q    <= wo_cnt_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            ro_data_v_q <= ro_data_v_d;
            rw_data_v_q <= rw_data_v_d;
        end
    end

    // Queue storage needs no reset; pointers and counts define validity.
    always_ff @(posedge clk_i) begin
        if (ro_enq) begin
            ro_mem_q[ro_wptr_q] <= bus.ro_addr_i;
        end
        if (wo_enq) begin
            wo_addr_mem_q[wo_wptr_q] <= bus.wo_addr_i;
            wo_data_mem_q[wo_wptr_q] <= bus.wo_data_i;
        end
    end

    assign bus.rw_yumi_o   = gnt_rw;
    assign bus.mem_v_o     = gnt_ro | gnt_wo | gnt_rw;
    assign bus.mem_w_o     = gnt_wo | (gnt_rw & bus.rw_w_i);
    assign bus.mem_addr_o  = gnt_ro ? ro_mem_q[ro_rptr_q]
                           : gnt_wo ? wo_addr_mem_q[wo_rptr_q]
                           : bus.rw_addr_i;
    assign bus.mem_data_o  = gnt_wo ? wo_data_mem_q[wo_rptr_q]
                           : bus.rw_data_i;
    assign bus.ro_data_o   = bus.mem_data_i;
    assign bus.rw_data_o   = bus.mem_data_i;
    assign bus.ro_data_v_o = ro_data_v_q;
    assign bus.rw_data_v_o = rw_data_v_q;
    assign bus.ro_count_o  = ro_cnt_q;
    assign bus.wo_count_o  = wo_cnt_q;
    assign bus.overflow_o  = overflow_q;
endmodule
